// File: rtl/decim2_d4_core_if.sv
// Stream bundle for decim2_d4_core: high-rate input samples (s_*) and the
// decimated output stream (m_*). The core binds the slave modport.
interface decim2_d4_core_if #(
  parameter int DATAPATH_WIDTH = 32
);
  logic                             s_valid;
  logic                             s_ready;
  logic signed [DATAPATH_WIDTH-1:0] s_data;
  logic                             m_valid;
  logic                             m_ready;
  logic signed [DATAPATH_WIDTH-1:0] m_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  m_valid,
    input  m_data,
    output m_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output m_valid,
    output m_data,
    input  m_ready
  );
endinterface

// File: rtl/decim2_d4_core.sv
// Second-order CIC decimator by 2^R_LOG2 with clamped, registered output.
// Define DECIM2_ROUND_EN for round-half-up scaling; default is truncation.
module decim2_d4_core #(
  parameter int DATAPATH_WIDTH = 32,
  parameter int R_LOG2         = 2
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             clear,
  input  logic                             en,
  input  logic signed [DATAPATH_WIDTH-1:0] min_Thold,
  input  logic signed [DATAPATH_WIDTH-1:0] max_Thold,
  decim2_d4_core_if.slave                  sif,
  output logic        [R_LOG2-1:0]         phase,
  output logic                             sat_flag
);

  localparam int G  = 2 * R_LOG2;
  localparam int DW = DATAPATH_WIDTH;
  localparam int W  = DW + G;

  logic signed [W-1:0] i1, i2, d_z1, c1_z1;
  logic signed [W-1:0] x, i1_n, i2_n, c1, c2;
  logic signed [W:0]   c2_ext, c2_adj, y_full, min_ext, max_ext;
  logic signed [DW-1:0] y_clamp, m_data_q;
  logic                 m_valid_q;
  logic                 last, stall, accept, load, over, under;

  // Only the last sample of a group needs the output register free.
  assign last   = &phase;
  assign stall  = last & m_valid_q & ~sif.m_ready;
  assign accept = sif.s_valid & sif.s_ready;
  assign load   = accept & last;

  assign sif.s_ready = en & ~stall;
  assign sif.m_valid = m_valid_q;
  assign sif.m_data  = m_data_q;

  assign x    = {{G{sif.s_data[DW-1]}}, sif.s_data};
  assign i1_n = i1 + x;
  assign i2_n = i2 + i1_n;
  assign c1   = i2_n - d_z1;
  assign c2   = c1 - c1_z1;

  // One guard bit above W keeps the rounding bias from wrapping the top code.
  assign c2_ext = {c2[W-1], c2};
`ifdef DECIM2_ROUND_EN
  localparam logic signed [W:0] RND_BIAS = (W+1)'(1) <<< (G - 1);
  assign c2_adj = c2_ext + RND_BIAS;
`else
  assign c2_adj = c2_ext;
`endif
  assign y_full = c2_adj >>> G;

  assign min_ext = {{(G+1){min_Thold[DW-1]}}, min_Thold};
  assign max_ext = {{(G+1){max_Thold[DW-1]}}, max_Thold};
  assign over    = y_full > max_ext;
  assign under   = y_full < min_ext;

  always_comb begin
    y_clamp = y_full[DW-1:0];
    if (over)
      y_clamp = max_Thold;
    else if (under)
      y_clamp = min_Thold;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i1        <= '0;
      i2        <= '0;
      d_z1      <= '0;
      c1_z1     <= '0;
      phase     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      sat_flag  <= 1'b0;
    end else if (clear) begin
      i1        <= '0;
      i2        <= '0;
      d_z1      <= '0;
      c1_z1     <= '0;
      phase     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (accept) begin
        i1    <= i1_n;
        i2    <= i2_n;
        phase <= phase + R_LOG2'(1);
      end
      if (load) begin
        d_z1      <= i2_n;
        c1_z1     <= c1;
        m_data_q  <= y_clamp;
        m_valid_q <= 1'b1;
        if (over || under)
          sat_flag <= 1'b1;
      end else if (m_valid_q && sif.m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decim2_d4_core.sv
// Bench for decim2_d4_core: directed and random stimulus against an FIR-form
// reference (triangular 1..R..1 kernel over accepted samples, scaled by R^2).
module tb_decim2_d4_core;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int R  = 1 << RL;
  localparam int G  = 2 * RL;
  localparam logic signed [DW-1:0] FULL_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] FULL_MAX = {1'b0, {(DW-1){1'b1}}};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clear = 1'b0;
  logic en = 1'b0;
  logic signed [DW-1:0] min_thold, max_thold;
  logic [RL-1:0] phase;
  logic sat_flag;

  int checks = 0;
  int failures = 0;

  longint hist[$];
  int     exp_phase;
  bit     exp_mv;
  longint exp_md;
  bit     exp_sat;

  decim2_d4_core_if #(.DATAPATH_WIDTH(DW)) bus ();

  decim2_d4_core #(.DATAPATH_WIDTH(DW), .R_LOG2(RL)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .en        (en),
    .min_Thold (min_thold),
    .max_Thold (max_thold),
    .sif       (bus),
    .phase     (phase),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void reset_model();
    hist.delete();
    exp_phase = 0;
    exp_mv    = 1'b0;
    exp_md    = 0;
    exp_sat   = 1'b0;
  endfunction

  // Triangular FIR over the most recent accepted samples, then scale by R^2.
  function automatic longint fir_out();
    longint acc = 0;
    for (int k = 0; k < 2*R-1; k++) begin
      int w = (k < R) ? k + 1 : 2*R - 1 - k;
      if (k < hist.size())
        acc += longint'(w) * hist[hist.size()-1-k];
    end
`ifdef DECIM2_ROUND_EN
    acc += longint'(1) << (G - 1);
`endif
    return acc >>> G;
  endfunction

  task automatic cycle();
    bit     rdy_exp, acc;
    longint y;
    @(negedge clk);
    rdy_exp = en && !(exp_phase == R-1 && exp_mv && !bus.m_ready);
    chk("s_ready", bus.s_ready, rdy_exp);
    acc = bus.s_valid && rdy_exp;
    if (clear) begin
      reset_model();
    end else begin
      if (exp_mv && bus.m_ready) exp_mv = 1'b0;
      if (acc) begin
        hist.push_back(longint'(bus.s_data));
        if (hist.size() > 2*R-1) void'(hist.pop_front());
        if (exp_phase == R-1) begin
          y = fir_out();
          if (y > longint'(max_thold)) begin
            y = longint'(max_thold);
            exp_sat = 1'b1;
          end else if (y < longint'(min_thold)) begin
            y = longint'(min_thold);
            exp_sat = 1'b1;
          end
          exp_md = y;
          exp_mv = 1'b1;
        end
        exp_phase = (exp_phase + 1) % R;
      end
    end
    @(posedge clk);
    #1;
    chk("phase", phase, exp_phase);
    chk("m_valid", bus.m_valid, exp_mv);
    chk("m_data", bus.m_data, exp_md);
    chk("sat_flag", sat_flag, exp_sat);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    min_thold   = FULL_MIN;
    max_thold   = FULL_MAX;
    reset_model();
    #1;
    chk("rst_phase", phase, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Constant 1600: 10/16 of the step on the first output, then full value.
    en = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'sd1600;
    run(4);
    chk("c1600_first", bus.m_data, 1000);
    run(4);
    chk("c1600_steady", bus.m_data, 1600);
    run(8);

    // Constant 1: first output depends on the rounding mode.
    do_clear();
    bus.s_data = 32'sd1;
    run(4);
`ifdef DECIM2_ROUND_EN
    chk("c1_first", bus.m_data, 1);
`else
    chk("c1_first", bus.m_data, 0);
`endif
    run(8);
    chk("c1_steady", bus.m_data, 1);

    // Clamp and sticky saturation.
    do_clear();
    bus.s_data = -32'sd1600;
    min_thold  = -32'sd800;
    max_thold  = 32'sd500;
    run(8);
    chk("clamp_lo", bus.m_data, -800);
    chk("clamp_sat", sat_flag, 1);
    min_thold = FULL_MIN;
    max_thold = FULL_MAX;
    run(8);
    chk("sat_sticky", sat_flag, 1);
    do_clear();
    chk("sat_cleared", sat_flag, 0);

    // Back-pressure stalls only the last sample of the group.
    bus.s_data = 32'sd1600;
    run(4);
    bus.m_ready = 1'b0;
    run(3);
    chk("bp_phase3", phase, 3);
    chk("bp_ready_low", bus.s_ready, 0);
    run(3);
    chk("bp_hold_phase", phase, 3);
    chk("bp_hold_data", bus.m_data, 1000);
    bus.m_ready = 1'b1;
    run(1);
    chk("bp_reload_valid", bus.m_valid, 1);
    chk("bp_reload_data", bus.m_data, 1600);

    // en low freezes everything while the output drains.
    run(3);
    en = 1'b0;
    run(4);
    en = 1'b1;
    run(4);

    // Asynchronous reset mid-group.
    do_clear();
    run(2);
    chk("mid_phase2", phase, 2);
    rstn = 1'b0;
    #1;
    chk("arst_phase", phase, 0);
    chk("arst_m_valid", bus.m_valid, 0);
    reset_model();
    #1;
    rstn = 1'b1;
    run(4);
    chk("arst_first", bus.m_data, 1000);
    run(4);
    chk("arst_steady", bus.m_data, 1600);

    // Same sequence using synchronous clear.
    do_clear();
    run(2);
    do_clear();
    chk("clr_phase", phase, 0);
    chk("clr_m_valid", bus.m_valid, 0);
    run(4);
    chk("clr_first", bus.m_data, 1000);
    run(4);
    chk("clr_steady", bus.m_data, 1600);

    // Full-scale input: integrators wrap, output settles on the top code.
    do_clear();
    bus.s_data = FULL_MAX;
    run(10000);
    chk("wrap_data", bus.m_data, longint'(FULL_MAX));
    chk("wrap_no_sat", sat_flag, 0);

    // Random traffic with occasional clears and threshold changes.
    do_clear();
    for (int i = 0; i < 3000; i++) begin
      logic signed [DW-1:0] a, b;
      bus.s_valid = ($urandom_range(0, 3) != 0);
      bus.m_ready = ($urandom_range(0, 2) != 0);
      en          = ($urandom_range(0, 7) != 0);
      clear       = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 2))
        0: bus.s_data = DW'($urandom);
        1: bus.s_data = DW'(signed'($urandom_range(0, 4000)) - 2000);
        default: bus.s_data = bus.s_data;
      endcase
      if ($urandom_range(0, 99) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          min_thold = FULL_MIN;
          max_thold = FULL_MAX;
        end else begin
          a = DW'($urandom);
          b = DW'($urandom);
          if (a > b) begin min_thold = b; max_thold = a; end
          else       begin min_thold = a; max_thold = b; end
        end
      end
      cycle();
    end
    clear = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decim2_d4_core.md
# decim2_D4_core

Streaming second-order CIC decimator by 2^R_LOG2 (default 4), the capture-side counterpart of the quadratic interpolator datapath. It consumes high-rate signed samples on a valid/ready input stream and produces one rounded, threshold-clamped low-rate sample per 2^R_LOG2 accepted inputs. The output side has a 1-deep skid-free output register.

## Interface
- DATAPATH_WIDTH, 32, width of input/output samples (signed two's complement)
- R_LOG2, 2, log2 of decimation factor R; gain growth G = 2*R_LOG2 bits; internal width W = DATAPATH_WIDTH+G
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous clear of all state (priority over all other inputs)
- en  in  1  enables input acceptance; output side drains regardless
- min_Thold  in  DATAPATH_WIDTH  signed lower clamp for output
- max_Thold  in  DATAPATH_WIDTH  signed upper clamp for output (max_Thold >= min_Thold required)
- s_valid  in  1  input sample valid
- s_ready  out  1  input ready (combinational)
- s_data  in  DATAPATH_WIDTH  signed input sample
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream ready
- m_data  out  DATAPATH_WIDTH  signed decimated sample
- phase  out  R_LOG2  input phase counter 0..R-1
- sat_flag  out  1  sticky: an output was clamped since last clear/reset

## Operation
- Reset/clear values: i1, i2, d_z1, c1_z1 = 0; phase = 0; m_valid = 0; m_data = 0; sat_flag = 0.
- s_ready = en & ~(phase==R-1 & m_valid & ~m_ready). Accept = s_valid & s_ready.
- On accept: x = sign-extend(s_data) to W; i1_n = i1 + x; i2_n = i2 + i1_n; i1 <= i1_n; i2 <= i2_n; phase <= phase+1 (wraps R-1 -> 0). All integrator/comb arithmetic is modulo 2^W; wrap is required and never flagged.
- On accept with phase==R-1 (decimation instant): d = i2_n; c1 = d - d_z1; c2 = c1 - c1_z1; d_z1 <= d; c1_z1 <= c1. Impulse response is 1,2,...,R,...,2,1 (sum R^2).
- Scaling: y = c2 >>> G (arithmetic), with rounding per Configuration; computed in W+1 bits so rounding cannot wrap.
- Clamp: y > max_Thold -> max_Thold; y < min_Thold -> min_Thold; else y[DATAPATH_WIDTH-1:0]. Clamping sets sat_flag.
- Output register: loads m_data, sets m_valid on decimation instant. m_valid clears on m_valid & m_ready with no simultaneous load. Simultaneous drain and load: new value loaded, m_valid stays 1.
- en=0: no acceptance, all state frozen; pending output still drains.
- Reset asserted mid-group: all state returns to reset values immediately; partial group discarded.
- Startup: first output reflects partial filter history (first R^2 weighting incomplete); no warm-up suppression.

## Timing
- Latency: m_valid rises the cycle after the accepting edge of the R-th sample of a group.
- Throughput: 1 input/cycle sustained when m_ready is high or output drained within R-1 cycles.
- Back-pressure only stalls the R-th sample of a group; phases 0..R-2 accept regardless of m_ready.
- m_data, m_valid stable while m_valid & ~m_ready.
- clear at a clock edge overrides any accept or load at that edge.

## Configuration
- DECIM2_ROUND_EN defined: round half up, y = (c2 + 2^(G-1)) >>> G.
- Not defined: truncation toward -inf, y = c2 >>> G; rounding adder absent.

## Test plan
- Constant s_data=1600, s_valid=1, m_ready=1, thresholds full-range -> outputs 1000, then 1600 steady; m_valid pulses every 4th cycle +1.
- Constant s_data=1 -> first output 1 with DECIM2_ROUND_EN (10/16 rounded), 0 without; steady 1 both.
- Constant s_data=-1600 with max_Thold=500, min_Thold=-800 -> outputs -800, -800; sat_flag=1 until clear.
- m_ready=0 after first output, s_valid=1 -> s_ready drops at phase 3; phase holds 3; m_data held; m_ready=1 -> accept and load same cycle, m_valid stays 1.
- Long run s_data=0x7FFFFFFF for 10^4 samples -> integrators wrap, outputs remain 0x7FFFFFFF (no spurious clamp with full-range thresholds).
- rstn low at phase 2, then constant 1600 -> phase=0, m_valid=0 immediately; restart gives 1000, 1600; repeat with clear -> identical.
